// File: rtl/alu.sv
// Registered WIDTH-bit ALU: one operation per cycle, result/carry one cycle after in_valid.
// Define ALU_FLAGS_EN to add registered zero and signed-overflow (ovf) flags.
module alu #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             out_valid
`ifdef ALU_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_e;

    op_e              op_sel;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] nxt_result;
    logic             nxt_carry;
    logic             nxt_ovf;

    assign op_sel = op_e'(op);
    assign sum    = {1'b0, a} + {1'b0, b};
    // The extra top bit of the widened difference is the borrow (a < b).
    assign diff   = {1'b0, a} - {1'b0, b};

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        nxt_result = '0;
        nxt_carry  = 1'b0;
        nxt_ovf    = 1'b0;
        case (op_sel)
            OP_ADD: begin
                nxt_result = sum[WIDTH-1:0];
                nxt_carry  = sum[WIDTH];
                nxt_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                nxt_result = diff[WIDTH-1:0];
                nxt_carry  = diff[WIDTH];
                nxt_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: nxt_result = a & b;
            OP_OR:  nxt_result = a | b;
            OP_XOR: nxt_result = a ^ b;
            OP_NOT: nxt_result = ~a;
            OP_SHL: begin
                nxt_result = {a[WIDTH-2:0], 1'b0};
                nxt_carry  = a[WIDTH-1];
            end
            OP_SHR: begin
                nxt_result = {1'b0, a[WIDTH-1:1]};
                nxt_carry  = a[0];
            end
            default: begin
                nxt_result = '0;
                nxt_carry  = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result    <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result <= nxt_result;
                carry  <= nxt_carry;
            end
        end
    end

`ifdef ALU_FLAGS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero <= 1'b0;
            ovf  <= 1'b0;
        end else if (in_valid) begin
            zero <= (nxt_result == '0);
            ovf  <= nxt_ovf;
        end
    end
`else
    logic unused_ovf;
    assign unused_ovf = nxt_ovf;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus randomized ops against an arithmetic model.
// Flag checks are compiled in when ALU_FLAGS_EN is defined.
module tb_alu;

    localparam int W    = 4;
    localparam int MOD  = 1 << W;
    localparam int HALF = 1 << (W - 1);

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] result;
    logic         carry;
    logic         out_valid;
`ifdef ALU_FLAGS_EN
    logic         zero;
    logic         ovf;
`endif

    alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .op        (op),
        .result    (result),
        .carry     (carry),
        .out_valid (out_valid)
`ifdef ALU_FLAGS_EN
        ,
        .zero      (zero),
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected architectural state of the ALU outputs.
    int exp_res   = 0;
    int exp_carry = 0;
    int exp_valid = 0;
    int exp_zero  = 0;
    int exp_ovf   = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v >= HALF) ? v - MOD : v;
    endfunction

    // Reference model computed from plain integer arithmetic.
    task automatic model_op(input int o, input int x, input int y,
                            output int r, output int c, output int v);
        int s;
        r = 0; c = 0; v = 0;
        case (o)
            0: begin
                s = x + y;
                r = s % MOD;
                c = (s >= MOD) ? 1 : 0;
                s = to_signed(x) + to_signed(y);
                v = (s < -HALF || s > HALF - 1) ? 1 : 0;
            end
            1: begin
                r = (x - y + MOD) % MOD;
                c = (x < y) ? 1 : 0;
                s = to_signed(x) - to_signed(y);
                v = (s < -HALF || s > HALF - 1) ? 1 : 0;
            end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: r = MOD - 1 - x;
            6: begin
                r = (x * 2) % MOD;
                c = (x >= HALF) ? 1 : 0;
            end
            default: begin
                r = x / 2;
                c = x % 2;
            end
        endcase
    endtask

    // Apply one cycle of stimulus, advance the model, and compare all outputs.
    task automatic step(input logic rst, input logic v, input int o, input int x, input int y);
        int r, c, f;
        rst_n    = rst;
        in_valid = v;
        op       = 3'(o);
        a        = W'(x);
        b        = W'(y);
        @(posedge clk);
        #1;
        if (!rst) begin
            exp_res = 0; exp_carry = 0; exp_valid = 0; exp_zero = 0; exp_ovf = 0;
        end else if (v) begin
            model_op(o, x, y, r, c, f);
            exp_res = r; exp_carry = c; exp_valid = 1;
            exp_zero = (r == 0) ? 1 : 0;
            exp_ovf = f;
        end else begin
            exp_valid = 0;
        end
        check("result", int'(result), exp_res);
        check("carry", int'(carry), exp_carry);
        check("out_valid", int'(out_valid), exp_valid);
`ifdef ALU_FLAGS_EN
        check("zero", int'(zero), exp_zero);
        check("ovf", int'(ovf), exp_ovf);
`endif
    endtask

    typedef struct {
        int o;
        int x;
        int y;
        int r;
        int c;
    } dir_t;

    dir_t dirs[$];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0;
        @(posedge clk);
        #1;

        // Operation during reset is discarded, then the same op completes after release.
        step(1'b0, 1'b1, 0, 'hF, 'h1);
        step(1'b1, 1'b1, 0, 'hF, 'h1);
        check("rst_release_res", int'(result), 0);
        check("rst_release_carry", int'(carry), 1);

        dirs = '{
            '{0, 'b0101, 'b0011, 'b1000, 0},
            '{1, 'b0110, 'b0010, 'b0100, 0},
            '{1, 'b0010, 'b0011, 'b1111, 1},
            '{2, 'b1100, 'b1010, 'b1000, 0},
            '{3, 'b1100, 'b1010, 'b1110, 0},
            '{4, 'b1100, 'b1010, 'b0110, 0},
            '{5, 'b1111, 'b0110, 'b0000, 0},
            '{6, 'b1001, 'b0111, 'b0010, 1},
            '{7, 'b1001, 'b0111, 'b0100, 1},
            '{0, 'b0111, 'b0001, 'b1000, 0},
            '{4, 'b0101, 'b0101, 'b0000, 0}
        };
        // Back-to-back directed ops, each also checked against its hand-computed answer.
        foreach (dirs[i]) begin
            step(1'b1, 1'b1, dirs[i].o, dirs[i].x, dirs[i].y);
            check($sformatf("dir%0d_res", i), int'(result), dirs[i].r);
            check($sformatf("dir%0d_carry", i), int'(carry), dirs[i].c);
        end
`ifdef ALU_FLAGS_EN
        check("xor_zero_flag", int'(zero), 1);
        step(1'b1, 1'b1, 0, 'b0111, 'b0001);
        check("add_ovf_flag", int'(ovf), 1);
        check("add_nonzero_flag", int'(zero), 0);
`endif

        // Idle cycles: out_valid drops, result and carry hold.
        step(1'b1, 1'b1, 6, 'b1001, 0);
        step(1'b1, 1'b0, 0, 'hF, 'hF);
        check("idle_hold_res", int'(result), 'b0010);
        step(1'b1, 1'b0, 1, 'h0, 'h1);
        check("idle_hold_carry", int'(carry), 1);

        // Randomized traffic with sparse idle cycles and an occasional reset.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, MOD - 1)),
                 int'($urandom_range(0, MOD - 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Registered 4-bit (parameterizable) arithmetic/logic unit: one operation per cycle, selected by a 3-bit opcode.
- Produces a result and a carry/borrow flag one clock after inputs are sampled.
- Sits in the datapath as a leaf compute block, fed by operand registers or a sequencer.
- Valid-in/valid-out qualifiers allow pipelined back-to-back operation.

Parameters:
- WIDTH, 4, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  a, b, op are valid and sampled this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  opcode.
- result  output  WIDTH  registered result.
- carry  output  1  registered carry/borrow/shift-out flag.
- out_valid  output  1  result/carry hold a newly computed value.

Behaviour:
- Reset: on a rising clk edge with rst_n=0, result=0, carry=0, out_valid=0. Reset overrides in_valid on the same edge; an operation presented during reset is discarded.
- Latency: exactly 1 cycle. Inputs sampled at edge N with in_valid=1 produce result/carry at edge N and out_valid=1 for the following cycle.
- Throughput: one operation per cycle. There is no backpressure.
- in_valid=0: result and carry hold their previous values; out_valid=0 on the next cycle.
- Opcodes (arithmetic is unsigned, carry is computed at WIDTH+1 bits):
  - 000 ADD: {carry,result} = a + b. carry=1 on unsigned overflow.
  - 001 SUB: result = (a - b) mod 2^WIDTH. carry = borrow = (a < b).
  - 010 AND: result = a & b, carry=0.
  - 011 OR: result = a | b, carry=0.
  - 100 XOR: result = a ^ b, carry=0.
  - 101 NOT: result = ~a, carry=0. b is ignored.
  - 110 SHL: result = a << 1, with LSB filled by 0. carry = a[WIDTH-1]. b is ignored.
  - 111 SHR: result = a >> 1 (logical), with MSB filled by 0. carry = a[0]. b is ignored.
- Wrap-around: ADD and SUB results wrap modulo 2^WIDTH. No saturation.
- Opcodes and operands containing X/Z are not specified. The implementation must be fully decoded so that no latches are inferred.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- Defined:
  - Adds output zero (1 bit): registered, set when the new result is all zeros.
  - Adds output ovf (1 bit): registered, signed two's-complement overflow for ADD/SUB, 0 for all other opcodes.
  - Both update with the same timing as result, and both reset to 0.
- Undefined: the zero and ovf ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset with in_valid=1, a=4'hF, b=4'h1, op=000 while rst_n=0 -> result=0, carry=0, out_valid=0. Release reset, present same op -> next cycle result=0000, carry=1, out_valid=1.
- ADD 0101+0011 -> result=1000, carry=0. SUB 0110-0010 -> result=0100, carry=0. SUB 0010-0011 -> result=1111, carry=1.
- a=1100, b=1010: AND -> 1000, OR -> 1110, XOR -> 0110, all with carry=0. NOT a=1111 -> result=0000, carry=0.
- SHL a=1001 -> result=0010, carry=1. SHR a=1001 -> result=0100, carry=1.
- Back-to-back ops on consecutive cycles, then in_valid=0 for 2 cycles -> one result per cycle at 1-cycle latency. out_valid drops and result/carry hold during idle.
- With ALU_FLAGS_EN: ADD 0111+0001 -> result=1000, ovf=1, zero=0. XOR 0101^0101 -> result=0000, zero=1, ovf=0.
